multicycle_adder: RTL and testbench

//  Sequential, parametrised add/subtract unit. Adds two WIDTH-bit operands one CHUNK-bit

---
 rtl/multicycle_adder_if.sv | 26 ++
 rtl/multicycle_adder.sv | 117 +++++++++++
 tb/tb_multicycle_adder.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_adder_if.sv
// Operand/result handshake bundle for the digit-serial add/subtract unit.
interface multicycle_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             C_out;
  logic             overflow;

  modport master (
    output in_valid, A, B, C_in, sub, out_ready,
    input  in_ready, out_valid, sum, C_out, overflow
  );

  modport slave (
    input  in_valid, A, B, C_in, sub, out_ready,
    output in_ready, out_valid, sum, C_out, overflow
  );
endinterface

// File: rtl/multicycle_adder.sv
// Digit-serial add/subtract: one CHUNK-bit digit per cycle, LSB first, carry held
// between digits; valid/ready on both sides, signed overflow and carry/borrow out.
module multicycle_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_adder_if.slave  bus
);

  localparam int unsigned N   = WIDTH / CHUNK;
  localparam int unsigned CW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_sub;
  logic             r_cout;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_last;
  int unsigned      w_base;
  logic [CHUNK-1:0] w_a_dig;
  logic [CHUNK-1:0] w_b_dig;
  logic [CHUNK-1:0] w_s_dig;
  logic             w_c_dig;

  assign w_last  = (r_cnt == CW'(N - 1));
  assign w_base  = 32'(r_cnt) * CHUNK;
  assign w_a_dig = r_a[w_base +: CHUNK];
  assign w_b_dig = r_b[w_base +: CHUNK];
  assign {w_c_dig, w_s_dig} = {1'b0, w_a_dig} + {1'b0, w_b_dig} + (CHUNK + 1)'(r_carry);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state and handshake decode
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand capture and per-digit accumulation; flags are settled on the last digit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= bus.A;
            r_b     <= bus.sub ? ~bus.B : bus.B;
            r_carry <= bus.C_in ^ bus.sub;
            r_sub   <= bus.sub;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_sum[w_base +: CHUNK] <= w_s_dig;
          r_carry                <= w_c_dig;
          r_cnt                  <= r_cnt + CW'(1);
          if (w_last) begin
            r_cout <= w_c_dig ^ r_sub;
            r_ovf  <= (r_a[MSB] == r_b[MSB]) && (w_s_dig[CHUNK-1] != r_a[MSB]);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE) && !reset;
  assign bus.out_valid = (r_state == DONE);
  assign bus.sum       = r_sum;
  assign bus.C_out     = r_cout;
  assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: directed corner cases, handshakes, abort, and random
// operands against an integer-arithmetic reference, on 16/4, 8/8 and 8/1 instances.
module tb_multicycle_adder;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  multicycle_adder_if #(.WIDTH(16)) if16 ();
  multicycle_adder_if #(.WIDTH(8))  if88 ();
  multicycle_adder_if #(.WIDTH(8))  if81 ();

  multicycle_adder #(.WIDTH(16), .CHUNK(4)) u_d16 (.clk(clk), .reset(reset), .bus(if16));
  multicycle_adder #(.WIDTH(8),  .CHUNK(8)) u_d88 (.clk(clk), .reset(reset), .bus(if88));
  multicycle_adder #(.WIDTH(8),  .CHUNK(1)) u_d81 (.clk(clk), .reset(reset), .bus(if81));

  function automatic int dut_w(input int d);
    return (d == 0) ? 16 : 8;
  endfunction

  function automatic int dut_n(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 1 : 8);
  endfunction

  task automatic drive_in(input int d, input bit v, input logic [15:0] a, input logic [15:0] b,
                          input bit cin, input bit s);
    case (d)
      0: begin if16.in_valid = v; if16.A = a; if16.B = b; if16.C_in = cin; if16.sub = s; end
      1: begin if88.in_valid = v; if88.A = a[7:0]; if88.B = b[7:0]; if88.C_in = cin; if88.sub = s; end
      default: begin if81.in_valid = v; if81.A = a[7:0]; if81.B = b[7:0]; if81.C_in = cin; if81.sub = s; end
    endcase
  endtask

  task automatic set_oready(input int d, input bit r);
    case (d)
      0: if16.out_ready = r;
      1: if88.out_ready = r;
      default: if81.out_ready = r;
    endcase
  endtask

  function automatic logic get_iready(input int d);
    case (d)
      0: return if16.in_ready;
      1: return if88.in_ready;
      default: return if81.in_ready;
    endcase
  endfunction

  function automatic logic get_ovalid(input int d);
    case (d)
      0: return if16.out_valid;
      1: return if88.out_valid;
      default: return if81.out_valid;
    endcase
  endfunction

  function automatic logic [15:0] get_sum(input int d);
    case (d)
      0: return if16.sum;
      1: return {8'h00, if88.sum};
      default: return {8'h00, if81.sum};
    endcase
  endfunction

  function automatic logic get_cout(input int d);
    case (d)
      0: return if16.C_out;
      1: return if88.C_out;
      default: return if81.C_out;
    endcase
  endfunction

  function automatic logic get_ovf(input int d);
    case (d)
      0: return if16.overflow;
      1: return if88.overflow;
      default: return if81.overflow;
    endcase
  endfunction

  // Reference: plain integer add/subtract on unsigned and signed interpretations
  task automatic ref_model(input int w, input logic [15:0] a, input logic [15:0] b,
                           input bit cin, input bit s,
                           output logic [15:0] rs, output bit rc, output bit rv);
    int mask, half, ua, ub, sa, sb, r, sr;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    ua   = int'(a) & mask;
    ub   = int'(b) & mask;
    sa   = (ua >= half) ? ua - (1 << w) : ua;
    sb   = (ub >= half) ? ub - (1 << w) : ub;
    r    = s ? (ua - ub - int'(cin)) : (ua + ub + int'(cin));
    sr   = s ? (sa - sb - int'(cin)) : (sa + sb + int'(cin));
    rs   = 16'(r & mask);
    rc   = s ? (r < 0) : (r > mask);
    rv   = (sr < -half) || (sr >= half);
  endtask

  // Issue one operation (called at a negedge), return results once out_valid rises
  task automatic do_op(input int d, input logic [15:0] a, input logic [15:0] b,
                       input bit cin, input bit s,
                       output logic [15:0] rs, output bit rc, output bit rv,
                       output int lat, output int acc, output bit ok);
    int guard;
    guard = 0;
    ok    = 1'b1;
    lat   = 0;
    acc   = 0;
    rs    = '0;
    rc    = 1'b0;
    rv    = 1'b0;
    drive_in(d, 1'b1, a, b, cin, s);
    while (!get_iready(d) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      ok = 1'b0;
      drive_in(d, 1'b0, a, b, cin, s);
      return;
    end
    acc = cyc;
    @(posedge clk);
    #1;
    drive_in(d, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    while (!get_ovalid(d) && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!get_ovalid(d)) begin
      ok = 1'b0;
      return;
    end
    rs = get_sum(d);
    rc = get_cout(d);
    rv = get_ovf(d);
    @(negedge clk);
  endtask

  task automatic release_out(input int d);
    set_oready(d, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_oready(d, 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (get_iready(0) !== 1'b0) begin
      n_err++; $display("FAIL reset_in_ready: got %b want 0", get_iready(0));
    end
    n_cmp++;
    if ({get_ovalid(0), get_sum(0), get_cout(0), get_ovf(0)} !== 19'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got ov=%b sum=%h c=%b v=%b want all 0",
               get_ovalid(0), get_sum(0), get_cout(0), get_ovf(0));
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (get_iready(d) !== 1'b1) begin
        n_err++; $display("FAIL reset_release_in_ready dut%0d: got %b want 1", d, get_iready(d));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [15:0] ta[5], tbv[5], es[5], rs;
    bit          tc[5], ts[5], ec[5], ev[5];
    bit          rc, rv, ok;
    int          lat, acc;
    ta  = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h1234};
    tbv = '{16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h4321};
    tc  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ts  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    es  = '{16'h0000, 16'h8000, 16'hFFFE, 16'h7FFE, 16'h5556};
    ec  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    ev  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      do_op(0, ta[i], tbv[i], tc[i], ts[i], rs, rc, rv, lat, acc, ok);
      n_cmp++;
      if (!ok || rs !== es[i] || rc !== ec[i] || rv !== ev[i] || lat != 4) begin
        n_err++;
        $display("FAIL directed_%0d: got ok=%b sum=%h c=%b v=%b lat=%0d want sum=%h c=%b v=%b lat=4",
                 i, ok, rs, rc, rv, lat, es[i], ec[i], ev[i]);
      end
      release_out(0);
    end
  endtask

  task automatic test_n1;
    logic [15:0] rs;
    bit          rc, rv, ok;
    int          lat, acc;
    do_op(1, 16'h00FF, 16'h00FF, 1'b1, 1'b0, rs, rc, rv, lat, acc, ok);
    n_cmp++;
    if (!ok || rs !== 16'h00FF || rc !== 1'b1 || rv !== 1'b0 || lat != 1) begin
      n_err++;
      $display("FAIL n1_ff_ff: got ok=%b sum=%h c=%b v=%b lat=%0d want sum=00ff c=1 v=0 lat=1",
               ok, rs, rc, rv, lat);
    end
    release_out(1);
  endtask

  task automatic test_backpressure;
    logic [15:0] rs, es;
    bit          rc, rv, ok, ec, ev;
    int          lat, acc;
    ref_model(16, 16'h1234, 16'h0F0F, 1'b0, 1'b0, es, ec, ev);
    do_op(0, 16'h1234, 16'h0F0F, 1'b0, 1'b0, rs, rc, rv, lat, acc, ok);
    n_cmp++;
    if (!ok || rs !== es) begin
      n_err++; $display("FAIL bp_first: got ok=%b sum=%h want %h", ok, rs, es);
    end
    for (int i = 0; i < 5; i++) begin
      drive_in(0, 1'(i % 2 == 0), 16'h0001 + 16'(i), 16'h0002, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      n_cmp++;
      if (get_ovalid(0) !== 1'b1 || get_sum(0) !== es || get_cout(0) !== ec ||
          get_ovf(0) !== ev || get_iready(0) !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold_%0d: got ov=%b sum=%h c=%b v=%b rdy=%b want ov=1 sum=%h c=%b v=%b rdy=0",
                 i, get_ovalid(0), get_sum(0), get_cout(0), get_ovf(0), get_iready(0), es, ec, ev);
      end
    end
    @(negedge clk);
    drive_in(0, 1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0);
    set_oready(0, 1'b1);
    @(posedge clk);
    #1;
    n_cmp++;
    if (get_ovalid(0) !== 1'b0 || get_iready(0) !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: got ov=%b rdy=%b want ov=0 rdy=1", get_ovalid(0), get_iready(0));
    end
    @(negedge clk);
    set_oready(0, 1'b0);
    do_op(0, 16'h0001, 16'h0002, 1'b0, 1'b0, rs, rc, rv, lat, acc, ok);
    n_cmp++;
    if (!ok || rs !== 16'h0003 || rc !== 1'b0 || rv !== 1'b0 || lat != 4) begin
      n_err++;
      $display("FAIL bp_next_op: got ok=%b sum=%h c=%b v=%b lat=%0d want sum=0003 c=0 v=0 lat=4",
               ok, rs, rc, rv, lat);
    end
    release_out(0);
  endtask

  task automatic test_abort;
    logic [15:0] rs;
    bit          rc, rv, ok;
    int          lat, acc, seen;
    drive_in(0, 1'b1, 16'hABCD, 16'h1111, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive_in(0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (get_ovalid(0) !== 1'b0 || get_sum(0) !== 16'h0000 || get_iready(0) !== 1'b0) begin
      n_err++;
      $display("FAIL abort_reset: got ov=%b sum=%h rdy=%b want ov=0 sum=0000 rdy=0",
               get_ovalid(0), get_sum(0), get_iready(0));
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (get_ovalid(0) === 1'b1 || get_iready(0) !== 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++; $display("FAIL abort_idle: got %0d non-idle cycles want 0", seen);
    end
    @(negedge clk);
    do_op(0, 16'h0010, 16'h0020, 1'b0, 1'b0, rs, rc, rv, lat, acc, ok);
    n_cmp++;
    if (!ok || rs !== 16'h0030 || rc !== 1'b0 || rv !== 1'b0 || lat != 4) begin
      n_err++;
      $display("FAIL abort_next_op: got ok=%b sum=%h c=%b v=%b lat=%0d want sum=0030 lat=4",
               ok, rs, rc, rv, lat);
    end
    release_out(0);
  endtask

  task automatic test_back_to_back;
    logic [15:0] rs, es;
    bit          rc, rv, ok, ec, ev;
    int          lat, acc, acc_prev;
    for (int d = 0; d < 3; d += 2) begin
      for (int k = 0; k < 2; k++) begin
        logic [15:0] a, b;
        a = 16'($urandom);
        b = 16'($urandom);
        if (d != 0) begin a[15:8] = 8'h00; b[15:8] = 8'h00; end
        ref_model(dut_w(d), a, b, 1'b1, 1'b1, es, ec, ev);
        do_op(d, a, b, 1'b1, 1'b1, rs, rc, rv, lat, acc, ok);
        n_cmp++;
        if (!ok || rs !== es || rc !== ec || rv !== ev) begin
          n_err++;
          $display("FAIL b2b_result dut%0d: got ok=%b sum=%h c=%b v=%b want sum=%h c=%b v=%b",
                   d, ok, rs, rc, rv, es, ec, ev);
        end
        if (k == 1) begin
          n_cmp++;
          if (acc - acc_prev != dut_n(d) + 2) begin
            n_err++;
            $display("FAIL b2b_interval dut%0d: got %0d want %0d", d, acc - acc_prev, dut_n(d) + 2);
          end
        end
        acc_prev = acc;
        release_out(d);
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] rs, es, a, b;
    bit          rc, rv, ok, ec, ev, cin, s;
    int          lat, acc, errs;
    for (int d = 0; d < 3; d++) begin
      errs = 0;
      for (int i = 0; i < 40; i++) begin
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom);
        s   = 1'($urandom);
        if (i == 0) begin a = 16'h8000; b = 16'h7FFF; end
        if (d != 0) begin a[15:8] = 8'h00; b[15:8] = 8'h00; end
        ref_model(dut_w(d), a, b, cin, s, es, ec, ev);
        do_op(d, a, b, cin, s, rs, rc, rv, lat, acc, ok);
        n_cmp++;
        if (!ok || rs !== es || rc !== ec || rv !== ev || lat != dut_n(d)) begin
          n_err++;
          errs++;
          if (errs <= 5)
            $display("FAIL random dut%0d a=%h b=%h cin=%b sub=%b: got sum=%h c=%b v=%b lat=%0d want sum=%h c=%b v=%b lat=%0d",
                     d, a, b, cin, s, rs, rc, rv, lat, es, ec, ev, dut_n(d));
        end
        release_out(d);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      drive_in(d, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      set_oready(d, 1'b0);
    end
    @(negedge clk);
    test_reset();
    test_directed();
    test_n1();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
